// File: rtl/cpu8_pkg.sv
// ---------------------------------------------------------------------------
// cpu8_pkg
// Shared definitions for the CPU_8bit instruction interface and for the
// instruction sequencer that drives it.
//   - opcode values carried in instruction[7:4]
//   - NOP_INSTR, the word driven whenever nothing is issued
//   - state encoding of the sequencer FSM
//   - is_legal_op(), which tells executable opcodes apart from illegal ones
// ---------------------------------------------------------------------------
package cpu8_pkg;

    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Opcode E is one the CPU ignores, so this word leaves the accumulator alone.
    localparam logic [7:0] NOP_INSTR = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    // HALT is handled separately by the sequencer, so it does not count as
    // legal here. The caller must exclude it before flagging an error.
    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_legal_op = 1'b1;
            default:                                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_rom_ram.sv
// ---------------------------------------------------------------------------
// instr_rom_ram
// DEPTH x 8 program store. Writes are synchronous. Reads are combinational,
// so the sequencer can fetch and issue a word in the same cycle.
// The contents are deliberately not reset.
// Ports:
//   clk    system clock
//   we     write strobe (already gated by the sequencer)
//   waddr  write address
//   wdata  write data
//   raddr  fetch address
//   rdata  word at raddr
// ---------------------------------------------------------------------------
module instr_rom_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // Program words survive reset, so this write port has no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Program-side driver for CPU_8bit. On start it resets the CPU for one cycle.
// It then issues one program word per clock. It waits one drain cycle for the
// last result to appear on cpu_result, captures that result, and pulses done.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   prog_we      program write strobe; ignored while busy
//   prog_addr    program write address
//   prog_data    program write data
//   prog_len     number of words to run; sampled on start and clamped to DEPTH
//   start        run request; accepted only in IDLE
//   instruction  instruction bus to the CPU
//   cpu_rst      one-cycle CPU reset, driven in CLR
//   cpu_result   accumulator from the CPU
//   busy         high from CLR through DRAIN
//   done         one-cycle completion pulse
//   result       captured accumulator
//   err          sticky illegal-opcode flag, cleared by the next accepted start
//   pc           current fetch address
// ---------------------------------------------------------------------------
module instr_sequencer
    import cpu8_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    output logic [7:0]        instruction,
    output logic              cpu_rst,
    input  logic [7:0]        cpu_result,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic              err,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    seq_state_t      state, next_state;
    logic [ADDR_W:0] len, count;
    logic [7:0]      fetch_word;
    logic [3:0]      fetch_op;
    logic            fetch_halt, fetch_illegal, last_issue;

    instr_rom_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (prog_we && !busy),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc),
        .rdata(fetch_word)
    );

    assign fetch_op      = fetch_word[7:4];
    assign fetch_halt    = (fetch_op == OP_HALT);
    assign fetch_illegal = !is_legal_op(fetch_op) && !fetch_halt;
    // This ISSUE cycle issues the final counted word of the run.
    assign last_issue    = ((count + 1'b1) == len);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. HALT ends the issue phase early and is not counted.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_CLR;
            ST_CLR:   next_state = (len == '0) ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: if (fetch_halt || last_issue) next_state = ST_DRAIN;
            ST_DRAIN: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs. Illegal opcodes and HALT are replaced by NOP on the bus, so
    // the CPU never sees them.
    always_comb begin
        instruction = NOP_INSTR;
        cpu_rst     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_CLR: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (!fetch_halt && !fetch_illegal) instruction = fetch_word;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Run bookkeeping. cpu_result already reflects the last issued word in
    // DRAIN, because the CPU executed that word at the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len    <= '0;
            count  <= '0;
            pc     <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len   <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        pc    <= '0;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (!fetch_halt) begin
                        pc    <= pc + 1'b1;
                        count <= count + 1'b1;
                        if (fetch_illegal) err <= 1'b1;
                    end
                end
                ST_DRAIN: result <= cpu_result;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer. A small CPU_8bit stand-in sits on
// the instruction bus. A trace model builds the whole expected run from the
// program contents on each accepted start. A negedge compare process checks
// every output against that trace, and directed tests pin known results.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    typedef struct packed {
        bit [7:0] instr;
        bit       cpu_rst;
        bit       busy;
        bit       done;
        bit [7:0] result;
        bit       err;
        bit [3:0] pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [4:0] prog_len = '0;
    logic       start = 1'b0;
    logic [7:0] instruction, cpu_result, result;
    logic       cpu_rst, busy, done, err;
    logic [3:0] pc;

    int   vectors = 0;
    int   miscompares = 0;
    bit   check_en = 1'b0;
    exp_t exp_cur;
    exp_t trace[$];
    bit [7:0] mem_m [16];
    logic [7:0] seen_instr [64];
    logic       seen_err [64];
    logic [7:0] t1_words [6] = '{8'h0A, 8'h13, 8'h21, 8'h35, 8'h43, 8'h51};
    logic [7:0] acc = 8'h00;

    always #5 clk = ~clk;

    instr_sequencer #(
        .DEPTH (16),
        .ADDR_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .start      (start),
        .instruction(instruction),
        .cpu_rst    (cpu_rst),
        .cpu_result (cpu_result),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err),
        .pc         (pc)
    );

    // Accumulator semantics of CPU_8bit; opcodes 6-F leave it untouched.
    function automatic bit [7:0] alu(input bit [7:0] a, input bit [7:0] w);
        bit [7:0] imm;
        imm = {4'h0, w[3:0]};
        case (w[7:4])
            4'h0:    return imm;
            4'h1:    return a + imm;
            4'h2:    return a - imm;
            4'h3:    return a & imm;
            4'h4:    return a | imm;
            4'h5:    return a ^ imm;
            default: return a;
        endcase
    endfunction

    // CPU stand-in: executes the word on the bus at each edge.
    always @(posedge clk) begin
        if (cpu_rst) acc <= 8'h00;
        else         acc <= alu(acc, instruction);
    end
    assign cpu_result = acc;

    function automatic exp_t reset_rec();
        exp_t r;
        r = '0;
        r.instr = 8'hE0;
        return r;
    endfunction

    // Builds the expected record for each cycle from CLR through DONE,
    // starting from the program image currently held in the model.
    task automatic build_trace();
        int       n, cnt;
        bit [3:0] p;
        bit [7:0] a, w;
        bit       e;
        exp_t     r;
        n = (prog_len > 5'd16) ? 16 : int'(prog_len);
        cnt = 0; p = '0; a = 8'h00; e = 1'b0;
        r = reset_rec();
        r.result = exp_cur.result;
        r.cpu_rst = 1'b1;
        r.busy = 1'b1;
        trace.push_back(r);
        r.cpu_rst = 1'b0;
        while (cnt < n) begin
            w = mem_m[p];
            r.pc = p;
            r.err = e;
            if (w[7:4] == 4'hF) begin
                r.instr = 8'hE0;
                trace.push_back(r);
                break;
            end
            if (w[7:4] >= 4'h6) begin
                r.instr = 8'hE0;
                e = 1'b1;
            end else begin
                r.instr = w;
                a = alu(a, w);
            end
            trace.push_back(r);
            p = p + 4'd1;
            cnt++;
        end
        r.instr = 8'hE0;
        r.pc = p;
        r.err = e;
        trace.push_back(r);
        r.busy = 1'b0;
        r.done = 1'b1;
        r.result = a;
        trace.push_back(r);
    endtask

    // Applies the effect of the clock edge that has just passed.
    task automatic model_advance();
        if (rst) begin
            trace.delete();
            exp_cur = reset_rec();
            return;
        end
        if (prog_we && !exp_cur.busy) mem_m[prog_addr] = prog_data;
        if (start && !exp_cur.busy && !exp_cur.done) build_trace();
        if (trace.size() > 0) begin
            exp_cur = trace.pop_front();
        end else begin
            exp_cur.instr = 8'hE0;
            exp_cur.cpu_rst = 1'b0;
            exp_cur.busy = 1'b0;
            exp_cur.done = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("instruction", {24'h0, instruction}, {24'h0, exp_cur.instr});
            checkOutput("cpu_rst", {31'h0, cpu_rst}, {31'h0, exp_cur.cpu_rst});
            checkOutput("busy", {31'h0, busy}, {31'h0, exp_cur.busy});
            checkOutput("done", {31'h0, done}, {31'h0, exp_cur.done});
            checkOutput("result", {24'h0, result}, {24'h0, exp_cur.result});
            checkOutput("err", {31'h0, err}, {31'h0, exp_cur.err});
            checkOutput("pc", {28'h0, pc}, {28'h0, exp_cur.pc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_advance();
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [7:0] data,
                                 input logic [4:0] len, input logic st);
        prog_we   = we;
        prog_addr = addr;
        prog_data = data;
        prog_len  = len;
        start     = st;
        tick();
    endtask

    // Starts a run and records the bus per cycle until done, within a cycle bound.
    task automatic run_timed(input logic [4:0] len, output int dc);
        dc = -1;
        applyStimulus(1'b0, 4'h0, 8'h00, len, 1'b1);
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            seen_instr[c] = instruction;
            seen_err[c] = err;
            if (done === 1'b1) begin
                dc = c;
                break;
            end
            applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);
        end
        prog_len = '0;
        start = 1'b0;
    endtask

    int       dc;
    bit [7:0] rw;

    initial begin
        $display("[TB] instr_sequencer bench starting");
        exp_cur = reset_rec();
        repeat (2) tick();
        rst = 1'b0;
        check_en = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 8'hE0, 5'd0, 1'b0);

        // Basic run
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i), t1_words[i], 5'd0, 1'b0);
        run_timed(5'd6, dc);
        checkOutput("t1_done_cycle", dc, 9);
        checkOutput("t1_result", {24'h0, result}, 32'h06);
        checkOutput("t1_err", {31'h0, err}, 32'h0);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("t1_instr_c%0d", i + 2), {24'h0, seen_instr[i+2]}, {24'h0, t1_words[i]});
        checkOutput("t1_instr_c8", {24'h0, seen_instr[8]}, 32'hE0);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // HALT
        applyStimulus(1'b1, 4'h0, 8'h0A, 5'd0, 1'b0);
        applyStimulus(1'b1, 4'h1, 8'hF0, 5'd0, 1'b0);
        applyStimulus(1'b1, 4'h2, 8'h13, 5'd0, 1'b0);
        run_timed(5'd3, dc);
        checkOutput("t2_done_cycle", dc, 5);
        checkOutput("t2_result", {24'h0, result}, 32'h0A);
        checkOutput("t2_pc", {28'h0, pc}, 32'h1);
        checkOutput("t2_instr_c3", {24'h0, seen_instr[3]}, 32'hE0);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // Empty run
        run_timed(5'd0, dc);
        checkOutput("t3_done_cycle", dc, 3);
        checkOutput("t3_result", {24'h0, result}, 32'h00);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // Illegal opcode, then a second start clears err
        applyStimulus(1'b1, 4'h0, 8'h05, 5'd0, 1'b0);
        applyStimulus(1'b1, 4'h1, 8'h72, 5'd0, 1'b0);
        applyStimulus(1'b1, 4'h2, 8'h11, 5'd0, 1'b0);
        run_timed(5'd3, dc);
        checkOutput("t4_instr_c3", {24'h0, seen_instr[3]}, 32'hE0);
        checkOutput("t4_instr_c4", {24'h0, seen_instr[4]}, 32'h11);
        checkOutput("t4_err", {31'h0, err}, 32'h1);
        checkOutput("t4_result", {24'h0, result}, 32'h06);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);
        run_timed(5'd3, dc);
        checkOutput("t4_err_cleared", {31'h0, seen_err[1]}, 32'h0);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // Reset mid-run, in cycle 4
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i), t1_words[i], 5'd0, 1'b0);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd6, 1'b1);
        repeat (3) applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);
        #2;
        rst = 1'b1;
        trace.delete();
        exp_cur = reset_rec();
        #1;
        checkOutput("t5_busy", {31'h0, busy}, 32'h0);
        checkOutput("t5_instr", {24'h0, instruction}, 32'hE0);
        checkOutput("t5_pc", {28'h0, pc}, 32'h0);
        checkOutput("t5_result", {24'h0, result}, 32'h00);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);
        rst = 1'b0;
        run_timed(5'd6, dc);
        checkOutput("t5_rerun_result", {24'h0, result}, 32'h06);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // Writes and starts while busy are ignored
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd6, 1'b1);
        for (int c = 1; c <= 8; c++) applyStimulus(1'b1, 4'h0, 8'hFF, 5'd6, 1'b1);
        prog_we = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("t6_done", {31'h0, done}, 32'h1);
        checkOutput("t6_result", {24'h0, result}, 32'h06);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);
        run_timed(5'd6, dc);
        checkOutput("t6_mem_kept", {24'h0, result}, 32'h06);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // prog_len clamps to DEPTH
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), {4'($urandom % 6), 4'($urandom)}, 5'd0, 1'b0);
        run_timed(5'd20, dc);
        checkOutput("t6_clamp_done_cycle", dc, 19);
        checkOutput("t6_clamp_pc", {28'h0, pc}, 32'h0);
        applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom % 4 == 0) rw = 8'($urandom);
            else                   rw = {4'($urandom % 6), 4'($urandom)};
            applyStimulus(1'($urandom % 3 == 0), 4'($urandom), rw,
                          5'($urandom % 21), 1'($urandom % 6 == 0));
        end
        repeat (30) applyStimulus(1'b0, 4'h0, 8'h00, 5'd0, 1'b0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program-side driver for CPU_8bit. It holds a small writable program memory and, on start, resets the CPU for one cycle. It then issues one instruction per clock on the CPU's instruction bus and captures the final accumulator from the CPU's output_data. It is the producer end of the instruction interface that CPU_8bit consumes, and it replaces hand-driven instruction stimulus in system-level runs.

Parameters:
DEPTH, 16, number of program words
ADDR_W, 4, program address width; DEPTH = 2**ADDR_W

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
prog_we  in  1  program write strobe; ignored while busy
prog_addr  in  ADDR_W  program write address
prog_data  in  8  program write data
prog_len  in  ADDR_W+1  number of words to run; sampled on start; values above DEPTH clamp to DEPTH
start  in  1  run request; ignored while busy
instruction  out  8  to CPU_8bit instruction
cpu_rst  out  1  to CPU_8bit rst
cpu_result  in  8  from CPU_8bit output_data
busy  out  1  high from CLR through DRAIN
done  out  1  one-cycle pulse in DONE
result  out  8  captured accumulator; holds until the next capture or rst
err  out  1  illegal opcode seen; sticky until the next accepted start
pc  out  ADDR_W  current fetch address

Behaviour:
- Instruction format: [7:4] opcode, [3:0] imm.
- Opcodes: 0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, F HALT. Opcodes 6-E are illegal.
- NOP encoding is 8'hE0. The CPU holds the accumulator on opcodes 6-F.
- The CPU executes the instruction present at each rising edge, so its result is visible on cpu_result in the next cycle.
- rst (asynchronous):
  - State goes to IDLE.
  - instruction=NOP, cpu_rst=0, busy=0, done=0, result=0, err=0, pc=0, internal count=0.
  - Program memory is not reset and keeps its contents.
- prog_we while busy=0 writes mem[prog_addr] at the clock edge.
- FSM states: IDLE, CLR, ISSUE, DRAIN, DONE. Cycle 0 is the cycle in which start is high in IDLE.
- IDLE:
  - start=1: latch len = min(prog_len, DEPTH), set pc=0, clear err, go to CLR.
- CLR (cycle 1):
  - cpu_rst=1, instruction=NOP, busy=1.
  - len=0: go to DRAIN. Otherwise go to ISSUE.
- ISSUE (cycles 2..):
  - Normal fetch: instruction=mem[pc]; at the edge pc++ and count++.
  - Leave for DRAIN after the edge on which count reaches len.
  - HALT fetched: drive NOP this cycle, hold pc, go to DRAIN. HALT uses one ISSUE cycle but is not counted as issued.
  - Illegal opcode fetched: drive NOP, set err, continue sequencing (pc and count advance).
- DRAIN:
  - instruction=NOP.
  - At the edge: result <= cpu_result; go to DONE.
- DONE:
  - done=1, busy=0, instruction=NOP.
  - Next state IDLE. start is not accepted in DONE.
- Latency for N words with no HALT: done is high in cycle N+3; busy is high in cycles 1..N+2.
- pc wraps naturally at DEPTH. It cannot exceed DEPTH-1 because len is clamped.
- Simultaneous prog_we and start in IDLE: the write and the start are both accepted. The written word is visible to the run if its address is fetched in cycle 2 or later.
- rst mid-run: immediate return to IDLE with reset output values. The CPU is not re-reset until the next CLR.

Decomposition:
- Shared package cpu8_pkg:
  - opcode localparams OP_LOAD..OP_XOR, OP_HALT=4'hF
  - NOP_INSTR=8'hE0
  - state encoding for the FSM
- One natural sub-module, instr_rom_ram: DEPTH x 8, synchronous write, combinational read. Fetch is combinational so that ISSUE achieves one instruction per cycle.

Test Plan:
1. Basic run: load program 0A,13,21,35,43,51, prog_len=6, start.
   -> cpu_rst high in cycle 1; instruction bus carries those words in cycles 2-7; NOP in cycle 8; done in cycle 9 with result=8'h06; err=0.
2. HALT: program 0A,F0,13, prog_len=3.
   -> only 0A is issued (cycle 2); NOP in cycle 3; done in cycle 5 with result=8'h0A; pc=1.
3. Empty run: prog_len=0.
   -> cpu_rst in cycle 1; DRAIN in cycle 2; done in cycle 3 with result=8'h00.
4. Illegal opcode: program 05,72,11, prog_len=3.
   -> instruction sequence 05,E0,11; err=1; result=8'h06; a second start clears err.
5. Reset mid-run: assert rst in cycle 4 of test 1.
   -> outputs go to reset values the same cycle without waiting for clk. A new start without reloading the program reproduces result=8'h06.
6. Busy protection:
   - prog_we and start while busy -> memory unchanged and the run is unaffected.
   - prog_len=20 -> runs 16 words; done in cycle 19.
